// File: rtl/recognize_pkg.sv
// Shared types for the "110" sequence recognizer and its consumers.
// Holds the recognizer state encoding, the state that denotes a match,
// and the report-register state encoding used by match_monitor.
package recognize_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  // The recognizer sits in this state for exactly the cycles that end a match.
  localparam state_t MATCH_STATE = S3;

  typedef enum logic {
    RPT_EMPTY = 1'b0,
    RPT_FULL  = 1'b1
  } rpt_state_t;

endpackage

// File: rtl/window_timer.sv
// Free-running window timer: counts 0..WINDOW-1 and flags the last cycle
// of every window with close. reset and clear both restart the count so
// the first window begins on the first cycle they are low.
module window_timer #(
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic close
);

  localparam int W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  logic [W-1:0] wcnt_q;
  logic [W-1:0] wcnt_d;

  // Terminal count detection and wrap.
  always_comb begin
    close  = (wcnt_q == W'(WINDOW - 1));
    wcnt_d = close ? '0 : wcnt_q + W'(1);
  end

  // Window position register; reset has priority over clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/match_monitor.sv
// match_monitor: counts recognizer match events (st == S3) over fixed
// windows of WINDOW cycles and posts each window's count through a
// one-entry report register.
//
// Report handshake: rpt_valid is high while a report is held; the report
// is consumed at the clock edge where rpt_valid && rpt_ready. A window
// closing while a report is still held overwrites it and raises the
// sticky rpt_drop flag, which falls at the next consumed report.
//
// Build option: define MATCH_MONITOR_SAT_EN to make the accumulator and the
// reported count saturate at all-ones instead of wrapping.
module match_monitor
  import recognize_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           st,
  input  logic             clear,
  output logic             match,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_drop
);

  logic             close;
  logic             ev;
  logic             hs;
  logic [CNT_W-1:0] sum;

  logic             match_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             drop_q;
  rpt_state_t       state_q;

  window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .close (close)
  );

  // Event detect and running sum including this cycle's event.
  always_comb begin
    ev = (st == MATCH_STATE);
    hs = (state_q == RPT_FULL) && rpt_ready;
`ifdef MATCH_MONITOR_SAT_EN
    sum = (ev && (acc_q != {CNT_W{1'b1}})) ? acc_q + CNT_W'(1) : acc_q;
`else
    sum = acc_q + CNT_W'(ev);
`endif
  end

  // Match pulse, accumulator and report FSM; reset beats clear, and clear
  // discards any close or handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      state_q <= RPT_EMPTY;
    end else begin
      match_q <= ev;
      if (clear) begin
        acc_q   <= '0;
        count_q <= '0;
        drop_q  <= 1'b0;
        state_q <= RPT_EMPTY;
      end else begin
        acc_q <= close ? '0 : sum;
        case (state_q)
          RPT_EMPTY: begin
            if (close) begin
              count_q <= sum;
              drop_q  <= 1'b0;
              state_q <= RPT_FULL;
            end
          end
          RPT_FULL: begin
            if (close) begin
              count_q <= sum;
              drop_q  <= !hs;
            end else if (hs) begin
              drop_q  <= 1'b0;
              state_q <= RPT_EMPTY;
            end
          end
          default: state_q <= RPT_EMPTY;
        endcase
      end
    end
  end

  assign match     = match_q;
  assign rpt_valid = (state_q == RPT_FULL);
  assign rpt_count = count_q;
  assign rpt_drop  = drop_q;

endmodule

// File: tb/tb_match_monitor.sv
// Testbench for match_monitor. Main instance: WINDOW=4, CNT_W=4, driven
// from a table of per-cycle inputs and the outputs expected after that
// cycle's clock edge. A second instance (WINDOW=32, CNT_W=3) exercises
// accumulator overflow with a hand-written sequence.
module tb_match_monitor;
  import recognize_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  state_t     st;
  logic       clear;
  logic       rpt_ready;
  logic       match;
  logic       rpt_valid;
  logic [3:0] rpt_count;
  logic       rpt_drop;

  state_t     st2;
  logic       clear2;
  logic       rpt_ready2;
  logic       match2;
  logic       rpt_valid2;
  logic [2:0] rpt_count2;
  logic       rpt_drop2;

  match_monitor #(.WINDOW(4), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .st        (st),
    .clear     (clear),
    .match     (match),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_drop  (rpt_drop)
  );

  match_monitor #(.WINDOW(32), .CNT_W(3)) dut_ovf (
    .clk       (clk),
    .reset     (reset),
    .st        (st2),
    .clear     (clear2),
    .match     (match2),
    .rpt_valid (rpt_valid2),
    .rpt_ready (rpt_ready2),
    .rpt_count (rpt_count2),
    .rpt_drop  (rpt_drop2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Apply current inputs across one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic   rst;
    logic   clr;
    logic   rdy;
    state_t s;
    int     m;
    int     v;
    int     c;   // -1: count not checked (report register empty)
    int     d;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic clr, input logic rdy,
                              input state_t s, input int m, input int v,
                              input int c, input int d);
    vec_t x;
    x.rst = rst; x.clr = clr; x.rdy = rdy; x.s = s;
    x.m = m; x.v = v; x.c = c; x.d = d;
    tbl.push_back(x);
  endfunction

  int exp_cnt2;

  initial begin
    // --- window 0: S0,S1,S2,S3; close on the S3 cycle ---
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S1, 0,0,0,0);
    add(0,0,0,S2, 0,0,0,0);
    add(0,0,0,S3, 1,1,1,0);
    // --- window 1: one event, not read -> overwrite, drop ---
    add(0,0,0,S3, 1,1,1,0);
    add(0,0,0,S0, 0,1,1,0);
    add(0,0,0,S0, 0,1,1,0);
    add(0,0,0,S0, 0,1,1,1);
    // --- window 2: two consecutive events, still not read ---
    add(0,0,0,S3, 1,1,1,1);
    add(0,0,0,S3, 1,1,1,1);
    add(0,0,0,S1, 0,1,1,1);
    add(0,0,0,S2, 0,1,2,1);
    // --- window 3: read on non-close cycle, ready while empty, one event ---
    add(0,0,1,S0, 0,0,-1,0);
    add(0,0,1,S0, 0,0,-1,0);
    add(0,0,0,S0, 0,0,-1,0);
    add(0,0,0,S3, 1,1,1,0);
    // --- window 4: three events, read exactly on close ---
    add(0,0,0,S3, 1,1,1,0);
    add(0,0,0,S3, 1,1,1,0);
    add(0,0,0,S0, 0,1,1,0);
    add(0,0,1,S3, 1,1,3,0);
    // --- window 5: read, then an empty window reports zero ---
    add(0,0,1,S0, 0,0,-1,0);
    add(0,0,0,S0, 0,0,-1,0);
    add(0,0,0,S0, 0,0,-1,0);
    add(0,0,0,S0, 0,1,0,0);
    // --- window 6: two events, then reset at wcnt=2 ---
    add(0,0,0,S3, 1,1,0,0);
    add(0,0,0,S3, 1,1,0,0);
    add(1,0,0,S3, 0,0,0,0);
    // --- first window after reset: closes 4 cycles after release ---
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S3, 1,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S0, 0,1,1,0);
    // --- two events, then clear with st=S3 while report held ---
    add(0,0,0,S3, 1,1,1,0);
    add(0,0,0,S3, 1,1,1,0);
    add(0,1,0,S3, 1,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S3, 1,1,1,0);
    // --- clear coinciding with close and handshake ---
    add(0,0,0,S0, 0,1,1,0);
    add(0,0,0,S0, 0,1,1,0);
    add(0,0,0,S0, 0,1,1,0);
    add(0,1,1,S3, 1,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S0, 0,0,0,0);
    add(0,0,0,S0, 0,1,0,0);

    // --- reset state ---
    reset = 1'b1; st = S0; clear = 1'b0; rpt_ready = 1'b0;
    st2 = S0; clear2 = 1'b0; rpt_ready2 = 1'b0;
    tick();
    tick();
    chk("reset match",     int'(match),     0);
    chk("reset rpt_valid", int'(rpt_valid), 0);
    chk("reset rpt_count", int'(rpt_count), 0);
    chk("reset rpt_drop",  int'(rpt_drop),  0);
    chk("reset ovf valid", int'(rpt_valid2), 0);

    // --- table-driven run on the WINDOW=4 instance ---
    for (int i = 0; i < tbl.size(); i++) begin
      reset     = tbl[i].rst;
      clear     = tbl[i].clr;
      rpt_ready = tbl[i].rdy;
      st        = tbl[i].s;
      tick();
      chk($sformatf("row%0d match", i),     int'(match),     tbl[i].m);
      chk($sformatf("row%0d rpt_valid", i), int'(rpt_valid), tbl[i].v);
      if (tbl[i].c >= 0)
        chk($sformatf("row%0d rpt_count", i), int'(rpt_count), tbl[i].c);
      chk($sformatf("row%0d rpt_drop", i),  int'(rpt_drop),  tbl[i].d);
    end
    reset = 1'b0; clear = 1'b0; rpt_ready = 1'b0; st = S0;

    // --- overflow: WINDOW=32, CNT_W=3, 16 events in one window ---
`ifdef MATCH_MONITOR_SAT_EN
    exp_cnt2 = 7;
`else
    exp_cnt2 = 0;
`endif
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("ovf clear valid", int'(rpt_valid2), 0);
    chk("ovf clear count", int'(rpt_count2), 0);
    for (int i = 0; i < 32; i++) begin
      st2 = (i < 16) ? S3 : S0;
      tick();
      if (i == 7)
        chk("ovf match pulse", int'(match2), 1);
      if (i == 30)
        chk("ovf valid before close", int'(rpt_valid2), 0);
    end
    st2 = S0;
    chk("ovf valid at close", int'(rpt_valid2), 1);
    chk("ovf rpt_count",      int'(rpt_count2), exp_cnt2);
    chk("ovf rpt_drop",       int'(rpt_drop2),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
